// File: rtl/time_set_controller.sv
// Time-setting sequencer: steps through seconds/minutes/hours, freezes counting while setting, and pulses commit when done.
// Optional inactivity timeout is enabled by defining TIMEOUT_EN.
module time_set_controller #(
  parameter int BLINK_CYCLES   = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [1:0] mode,
  output logic [5:0] val,
  output logic       run_en,
  output logic       commit,
  output logic       blink
);

  // state   | meaning
  // RUN     | clock counting, no field selected
  // SET_SEC | adjusting seconds, counting frozen
  // SET_MIN | adjusting minutes, counting frozen
  // SET_HRS | adjusting hours, counting frozen
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_SEC = 2'd1,
    SET_MIN = 2'd2,
    SET_HRS = 2'd3
  } state_t;

  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);

  state_t        state, state_n;
  logic [5:0]    val_n;
  logic          run_en_n, commit_n, blink_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          abort, adj_up, adj_dn, timeout_hit;
  logic [5:0]    fmax;

  function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] m);
    return (v > m) ? m : v;
  endfunction

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          any_btn;

  assign any_btn     = btn_next | btn_up | btn_down | btn_cancel;
  assign timeout_hit = (state != RUN) && (tcnt == '0);

  always_ff @(posedge clk) begin
    if (reset)
      tcnt <= TIMEOUT_RELOAD;
    else if ((state == RUN) || (state_n != state) || any_btn)
      tcnt <= TIMEOUT_RELOAD;
    else if (tcnt != '0)
      tcnt <= tcnt - 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
`endif

  assign abort  = btn_cancel | timeout_hit;
  assign adj_up = btn_up & ~btn_down;
  assign adj_dn = btn_down & ~btn_up;
  assign fmax   = (state == SET_HRS) ? 6'd23 : 6'd59;
  assign mode   = state;

  always_comb begin
    state_n  = state;
    val_n    = val;
    run_en_n = run_en;
    commit_n = 1'b0;
    blink_n  = blink;
    bcnt_n   = bcnt;

    if (state == RUN) begin
      if (btn_next) begin
        state_n  = SET_SEC;
        val_n    = clamp(cur_sec, 6'd59);
        run_en_n = 1'b0;
      end
    end else if (abort) begin
      state_n  = RUN;
      val_n    = '0;
      run_en_n = 1'b1;
    end else if (btn_next) begin
      case (state)
        SET_SEC: begin
          state_n = SET_MIN;
          val_n   = clamp(cur_min, 6'd59);
        end
        SET_MIN: begin
          state_n = SET_HRS;
          val_n   = clamp({1'b0, cur_hrs}, 6'd23);
        end
        default: begin
          state_n  = RUN;
          val_n    = '0;
          run_en_n = 1'b1;
          commit_n = 1'b1;
        end
      endcase
    end else if (adj_up) begin
      val_n = (val >= fmax) ? 6'd0 : val + 6'd1;
    end else if (adj_dn) begin
      val_n = (val == 6'd0) ? fmax : val - 6'd1;
    end

    // Restart the blink phase on every entry so the new field shows at once.
    if (state_n == RUN) begin
      blink_n = 1'b0;
      bcnt_n  = '0;
    end else if (state_n != state) begin
      blink_n = 1'b1;
      bcnt_n  = BLINK_RELOAD;
    end else if (bcnt == '0) begin
      blink_n = ~blink;
      bcnt_n  = BLINK_RELOAD;
    end else begin
      bcnt_n = bcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      val    <= '0;
      run_en <= 1'b1;
      commit <= 1'b0;
      blink  <= 1'b0;
      bcnt   <= '0;
    end else begin
      state  <= state_n;
      val    <= val_n;
      run_en <= run_en_n;
      commit <= commit_n;
      blink  <= blink_n;
      bcnt   <= bcnt_n;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: driver queues expected outputs, monitor checks them after each edge.
module tb_time_set_controller;
  localparam int BLINK = 40;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [4:0] cur_hrs = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [1:0] mode;
  logic [5:0] val;
  logic       run_en, commit, blink;

  logic [4:0] ch = 5'd0;
  logic [5:0] cm = 6'd30, cs = 6'd58;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [5:0] val;
    logic       run_en;
    logic       commit;
    logic       blink;
    logic       chk_blink;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  time_set_controller #(.BLINK_CYCLES(BLINK), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cur_hrs(cur_hrs), .cur_min(cur_min), .cur_sec(cur_sec),
    .mode(mode), .val(val), .run_en(run_en), .commit(commit), .blink(blink)
  );

  always #5 clk = ~clk;

  // One call per cycle: drive inputs at the falling edge, queue what the next rising edge must produce.
  task automatic step(input string nm, input logic rs, input logic nx, input logic up,
                      input logic dn, input logic cn, input logic [1:0] m, input logic [5:0] v,
                      input logic re, input logic cmt, input logic bl, input logic cb);
    exp_t e;
    @(negedge clk);
    reset = rs; btn_next = nx; btn_up = up; btn_down = dn; btn_cancel = cn;
    cur_hrs = ch; cur_min = cm; cur_sec = cs;
    e.name = nm; e.mode = m; e.val = v; e.run_en = re; e.commit = cmt;
    e.blink = bl; e.chk_blink = cb;
    sb.push_back(e);
  endtask

  task automatic run_idle(input string nm);
    step(nm, 0, 0, 0, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (mode !== e.mode || val !== e.val || run_en !== e.run_en || commit !== e.commit ||
            (e.chk_blink && blink !== e.blink)) begin
          errors++;
          $display("FAIL %s: got mode=%0d val=%0d run_en=%0b commit=%0b blink=%0b, want mode=%0d val=%0d run_en=%0b commit=%0b blink=%0b",
                   e.name, mode, val, run_en, commit, blink, e.mode, e.val, e.run_en, e.commit, e.blink);
        end
      end
    end
  end

  initial begin : driver
    // reset and RUN-state ignores
    step("reset0", 1, 0, 0, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    step("reset1", 1, 0, 0, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    step("run_up",     0, 0, 1, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    step("run_down",   0, 0, 0, 1, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    step("run_cancel", 0, 0, 0, 0, 1, 2'd0, 6'd0, 1, 0, 0, 1);

    // seconds wrap upward and downward
    step("sec_load", 0, 1, 0, 0, 0, 2'd1, 6'd58, 0, 0, 1, 1);
    step("sec_up1",  0, 0, 1, 0, 0, 2'd1, 6'd59, 0, 0, 1, 1);
    step("sec_up2",  0, 0, 1, 0, 0, 2'd1, 6'd0,  0, 0, 1, 1);
    step("sec_up3",  0, 0, 1, 0, 0, 2'd1, 6'd1,  0, 0, 1, 1);
    step("sec_dn1",  0, 0, 0, 1, 0, 2'd1, 6'd0,  0, 0, 1, 1);
    step("sec_dn2",  0, 0, 0, 1, 0, 2'd1, 6'd59, 0, 0, 1, 1);
    step("sec_cancel", 0, 0, 0, 0, 1, 2'd0, 6'd0, 1, 0, 0, 1);

    // hours wrap, then commit
    step("h_sec", 0, 1, 0, 0, 0, 2'd1, 6'd58, 0, 0, 1, 1);
    step("h_min", 0, 1, 0, 0, 0, 2'd2, 6'd30, 0, 0, 1, 1);
    step("h_hrs", 0, 1, 0, 0, 0, 2'd3, 6'd0,  0, 0, 1, 1);
    step("h_dn",  0, 0, 0, 1, 0, 2'd3, 6'd23, 0, 0, 1, 1);
    step("h_up",  0, 0, 1, 0, 0, 2'd3, 6'd0,  0, 0, 1, 1);
    step("h_updn", 0, 0, 1, 1, 0, 2'd3, 6'd0, 0, 0, 1, 1);
    step("h_commit", 0, 1, 0, 0, 0, 2'd0, 6'd0, 1, 1, 0, 1);
    run_idle("h_commit_clear");

    // straight 4x next
    ch = 5'd12;
    step("seq1", 0, 1, 0, 0, 0, 2'd1, 6'd58, 0, 0, 1, 1);
    step("seq2", 0, 1, 0, 0, 0, 2'd2, 6'd30, 0, 0, 1, 1);
    step("seq3", 0, 1, 0, 0, 0, 2'd3, 6'd12, 0, 0, 1, 1);
    step("seq4", 0, 1, 0, 0, 0, 2'd0, 6'd0,  1, 1, 0, 1);
    run_idle("seq_commit_clear");

    // next beats adjust, up+down cancels out, cancel gives no commit
    step("p_sec", 0, 1, 0, 0, 0, 2'd1, 6'd58, 0, 0, 1, 1);
    step("p_min", 0, 1, 0, 0, 0, 2'd2, 6'd30, 0, 0, 1, 1);
    step("p_next_up", 0, 1, 1, 0, 0, 2'd3, 6'd12, 0, 0, 1, 1);
    step("p_updn",    0, 0, 1, 1, 0, 2'd3, 6'd12, 0, 0, 1, 1);
    step("p_cancel",  0, 0, 0, 0, 1, 2'd0, 6'd0,  1, 0, 0, 1);
    run_idle("p_no_commit");

    // corrupt inputs clamp on load
    cs = 6'd63; cm = 6'd60; ch = 5'd31;
    step("c_sec", 0, 1, 0, 0, 0, 2'd1, 6'd59, 0, 0, 1, 1);
    step("c_min", 0, 1, 0, 0, 0, 2'd2, 6'd59, 0, 0, 1, 1);
    step("c_hrs", 0, 1, 0, 0, 0, 2'd3, 6'd23, 0, 0, 1, 1);
    step("c_up",  0, 0, 1, 0, 0, 2'd3, 6'd0,  0, 0, 1, 1);
    step("c_cancel", 0, 0, 0, 0, 1, 2'd0, 6'd0, 1, 0, 0, 1);

    // cancel beats next; reset mid-sequence
    cs = 6'd10; cm = 6'd45; ch = 5'd7;
    step("k_sec", 0, 1, 0, 0, 0, 2'd1, 6'd10, 0, 0, 1, 1);
    step("k_all", 0, 1, 1, 0, 1, 2'd0, 6'd0,  1, 0, 0, 1);
    step("r_sec", 0, 1, 0, 0, 0, 2'd1, 6'd10, 0, 0, 1, 1);
    step("r_up",  0, 0, 1, 0, 0, 2'd1, 6'd11, 0, 0, 1, 1);
    step("r_reset", 1, 0, 0, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    run_idle("r_after");

    // blink stays high BLINK cycles from entry, then toggles; re-entry restarts it
    step("b_entry", 0, 1, 0, 0, 0, 2'd1, 6'd10, 0, 0, 1, 1);
    for (int i = 1; i < BLINK; i++)
      step("b_high", 0, 0, 0, 0, 0, 2'd1, 6'd10, 0, 0, 1, 1);
    step("b_toggle", 0, 0, 0, 0, 0, 2'd1, 6'd10, 0, 0, 0, 1);
    step("b_reentry", 0, 1, 0, 0, 0, 2'd2, 6'd45, 0, 0, 1, 1);
    step("b_cancel", 0, 0, 0, 0, 1, 2'd0, 6'd0, 1, 0, 0, 1);

`ifdef TIMEOUT_EN
    step("t_entry", 0, 1, 0, 0, 0, 2'd1, 6'd10, 0, 0, 1, 1);
    for (int i = 1; i < 50; i++)
      step("t_idle_a", 0, 0, 0, 0, 0, 2'd1, 6'd10, 0, 0, 0, 0);
    step("t_up", 0, 0, 1, 0, 0, 2'd1, 6'd11, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++)
      step("t_idle_b", 0, 0, 0, 0, 0, 2'd1, 6'd11, 0, 0, 0, 0);
    step("t_expire", 0, 0, 0, 0, 0, 2'd0, 6'd0, 1, 0, 0, 1);
    run_idle("t_after");
`endif

    @(negedge clk);
    btn_next = 0; btn_up = 0; btn_down = 0; btn_cancel = 0; reset = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
